// File: rtl/vc_mux_rr.sv
// vc_mux_rr: NUM_VC-to-1 virtual-channel mux with registered output; VC_MUX_RR_EN selects round-robin, else fixed priority
module vc_mux_rr #(
  parameter int BITNUMBER = 5,
  parameter int NUM_VC = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_VC-1:0]           valid_vc,
  input  logic [NUM_VC*BITNUMBER-1:0] data_in,
  input  logic                        pause_dest,
  output logic [NUM_VC-1:0]           pop_vc,
  output logic [BITNUMBER-1:0]        data_out_dest,
  output logic                        valid_out_dest
);
  localparam int PW = $clog2(NUM_VC);
  logic [PW-1:0] gnt;
  logic hit;
  logic go;
  int j;
`ifdef VC_MUX_RR_EN
  logic [PW-1:0] rr_ptr;
`endif
  // scan offsets from last to first so the first requester at or after the start point wins
  always_comb begin
    gnt = '0;
    hit = 1'b0;
    j = 0;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
`ifdef VC_MUX_RR_EN
      j = (int'(rr_ptr) + k) % NUM_VC;
`else
      j = k;
`endif
      if (valid_vc[j]) begin
        gnt = PW'(j);
        hit = 1'b1;
      end
    end
  end
  assign go = hit & ~reset & ~pause_dest;
  assign pop_vc = go ? {{(NUM_VC-1){1'b0}}, 1'b1} << gnt : '0;
  // output register: capture granted word, otherwise drop valid and hold data
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_dest <= '0;
      valid_out_dest <= 1'b0;
    end else begin
      valid_out_dest <= go;
      if (go) data_out_dest <= data_in[int'(gnt)*BITNUMBER +: BITNUMBER];
    end
  end
`ifdef VC_MUX_RR_EN
  // pointer moves just past the granted channel, wrapping after the last one
  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= '0;
    else if (go) rr_ptr <= (int'(gnt) == NUM_VC - 1) ? '0 : gnt + 1'b1;
  end
`endif
endmodule

// File: tb/tb_vc_mux_rr.sv
// tb_vc_mux_rr: scoreboard bench for vc_mux_rr (expects round-robin when VC_MUX_RR_EN is defined, fixed priority otherwise)
module tb_vc_mux_rr;
  localparam int BW = 5;
  localparam int NV = 2;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pause_dest = 1'b0;
  logic [NV-1:0] valid_vc = '0;
  logic [NV*BW-1:0] data_in = '0;
  logic [NV-1:0] pop_vc;
  logic [BW-1:0] data_out_dest;
  logic valid_out_dest;
  int passed = 0;
  int total = 0;
  int m_ptr = 0;
  logic m_valid = 1'b0;
  logic [BW-1:0] m_data = '0;
  logic [BW-1:0] sb[$];
  logic [NV-1:0] ep;
  logic [BW-1:0] ed;

  always #5 clk = ~clk;

  vc_mux_rr #(.BITNUMBER(BW), .NUM_VC(NV)) dut (
    .clk(clk),
    .reset(reset),
    .valid_vc(valid_vc),
    .data_in(data_in),
    .pause_dest(pause_dest),
    .pop_vc(pop_vc),
    .data_out_dest(data_out_dest),
    .valid_out_dest(valid_out_dest)
  );

  function automatic logic [NV-1:0] model_pop();
    logic [NV-1:0] p;
    int s;
    p = '0;
`ifdef VC_MUX_RR_EN
    s = m_ptr;
`else
    s = 0;
`endif
    if (!reset && !pause_dest)
      for (int k = NV - 1; k >= 0; k--)
        if (valid_vc[(s + k) % NV]) begin
          p = '0;
          p[(s + k) % NV] = 1'b1;
        end
    return p;
  endfunction

  task automatic advance(input logic [NV-1:0] p);
    int g;
    g = 0;
    if (reset) begin
      m_ptr = 0;
      m_valid = 1'b0;
      m_data = '0;
    end else if (p != '0) begin
      for (int k = 0; k < NV; k++) if (p[k]) g = k;
      m_data = data_in[g*BW +: BW];
      sb.push_back(m_data);
      m_valid = 1'b1;
      m_ptr = (g + 1) % NV;
    end else m_valid = 1'b0;
  endtask

  task automatic drive(input logic r, input logic pz, input logic [NV-1:0] v, input logic [BW-1:0] d0, input logic [BW-1:0] d1);
    reset = r;
    pause_dest = pz;
    valid_vc = v;
    data_in = {d1, d0};
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 2'b11, 5'd1, 5'd2);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (pop_vc !== 2'b00) $display("FAIL reset_pop got=%b exp=00", pop_vc);
      else passed++;
      advance(2'b00);
      @(posedge clk); #1;
      total++;
      if (valid_out_dest !== 1'b0 || data_out_dest !== 5'd0)
        $display("FAIL reset_out got valid=%b data=%0d exp valid=0 data=0", valid_out_dest, data_out_dest);
      else passed++;
    end
  endtask

  task automatic test_single();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b0, c == 0 ? 2'b01 : 2'b00, 5'd4, 5'd0);
      @(negedge clk);
      ep = model_pop();
      total++;
      if (pop_vc !== ep) $display("FAIL single_pop cyc=%0d got=%b exp=%b", c, pop_vc, ep);
      else passed++;
      advance(ep);
      @(posedge clk); #1;
      ed = m_valid ? sb.pop_front() : m_data;
      total++;
      if (valid_out_dest !== m_valid || data_out_dest !== ed)
        $display("FAIL single_out cyc=%0d got valid=%b data=%0d exp valid=%b data=%0d", c, valid_out_dest, data_out_dest, m_valid, ed);
      else passed++;
    end
  endtask

  task automatic test_contention();
    int grants [NV];
    for (int k = 0; k < NV; k++) grants[k] = 0;
    drive(1'b0, 1'b0, 2'b11, 5'd6, 5'd3);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ep = model_pop();
      total++;
      if (pop_vc !== ep) $display("FAIL contention_pop cyc=%0d got=%b exp=%b", c, pop_vc, ep);
      else passed++;
      for (int k = 0; k < NV; k++) if (pop_vc[k]) grants[k]++;
      advance(ep);
      @(posedge clk); #1;
      ed = m_valid ? sb.pop_front() : m_data;
      total++;
      if (valid_out_dest !== m_valid || data_out_dest !== ed)
        $display("FAIL contention_out cyc=%0d got valid=%b data=%0d exp valid=%b data=%0d", c, valid_out_dest, data_out_dest, m_valid, ed);
      else passed++;
    end
`ifdef VC_MUX_RR_EN
    total++;
    if (grants[0] != 3 || grants[1] != 3) $display("FAIL contention_fair got ch0=%0d ch1=%0d exp 3 each", grants[0], grants[1]);
    else passed++;
`else
    total++;
    if (grants[0] != 6 || grants[1] != 0) $display("FAIL contention_prio got ch0=%0d ch1=%0d exp 6 and 0", grants[0], grants[1]);
    else passed++;
`endif
  endtask

  task automatic test_back_pressure();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, c < 3, c < 4 ? 2'b10 : 2'b00, 5'd0, 5'd9);
      @(negedge clk);
      ep = model_pop();
      total++;
      if (pop_vc !== ep) $display("FAIL pause_pop cyc=%0d got=%b exp=%b", c, pop_vc, ep);
      else passed++;
      advance(ep);
      @(posedge clk); #1;
      ed = m_valid ? sb.pop_front() : m_data;
      total++;
      if (valid_out_dest !== m_valid || data_out_dest !== ed)
        $display("FAIL pause_out cyc=%0d got valid=%b data=%0d exp valid=%b data=%0d", c, valid_out_dest, data_out_dest, m_valid, ed);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 6; c++) begin
      drive(c == 3, 1'b0, 2'b11, 5'd11, 5'd22);
      @(negedge clk);
      ep = model_pop();
      total++;
      if (pop_vc !== ep) $display("FAIL midreset_pop cyc=%0d got=%b exp=%b", c, pop_vc, ep);
      else passed++;
      if (c == 4) begin
        total++;
        if (pop_vc !== 2'b01) $display("FAIL midreset_first got=%b exp=01", pop_vc);
        else passed++;
      end
      advance(ep);
      @(posedge clk); #1;
      ed = m_valid ? sb.pop_front() : m_data;
      total++;
      if (valid_out_dest !== m_valid || data_out_dest !== ed)
        $display("FAIL midreset_out cyc=%0d got valid=%b data=%0d exp valid=%b data=%0d", c, valid_out_dest, data_out_dest, m_valid, ed);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_reset_mid();
    total++;
    if (sb.size() != 0) $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
